fc_input_streamer: RTL and testbench
====================================

// Module: fc_input_streamer
// PURPOSE
//  Transmit side of the fully-connected layer input protocol. Collects one flattened
//  3-channel feature frame from the pooling stage into a ping-pong buffer, then replays
//  it to the FC layer: FRAME_LEN feature beats, then COMPUTE_BEATS compute strobes.
//  Sits between the last max-pool stage and the fully_connected block.
// PARAMETERS
//  FRAME_LEN      16  beats per frame (per-channel feature count; FC fill depth)
//  COMPUTE_BEATS  11  strobe beats after features (OUTPUT_NUM + 1 masked first result)
//  GAP_CYCLES     0   idle cycles forced between frames on the TX side
//  DW             12  sample width, signed two's complement
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  valid_in     in   1   upstream beat valid
//  data_in_1    in   DW  channel 1 sample
//  data_in_2    in   DW  channel 2 sample
//  data_in_3    in   DW  channel 3 sample
//  in_ready     out  1   buffer bank free; beat accepted when valid_in & in_ready
//  valid_out    out  1   beat to FC (drives FC valid_in)
//  data_out_1   out  DW  channel 1 to FC (zero during strobes)
//  data_out_2   out  DW  channel 2 to FC
//  data_out_3   out  DW  channel 3 to FC
//  busy         out  1   TX FSM not IDLE
//  frame_sent   out  1   one-cycle pulse on last strobe beat
// BEHAVIOUR
//  Reset: in_ready=1, valid_out=0, data_out_*=0, busy=0, frame_sent=0; both banks empty,
//   wr_bank=rd_bank=0, counters 0, FSM IDLE. Mid-frame reset discards partial data.
//  Write side: accept writes {d1,d2,d3} to bank[wr_bank][wr_cnt]; wr_cnt++.
//   On accept with wr_cnt==FRAME_LEN-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
//   in_ready = !full[wr_bank] (registered flag, no combinational path from valid_in).
//  TX FSM (all outputs registered):
//   IDLE : if full[rd_bank] -> FEAT, rd_cnt=0.
//   FEAT : valid_out=1, data_out_* = bank[rd_bank][rd_cnt]; one beat/cycle, no stalls;
//          after beat FRAME_LEN-1 -> STRB.
//   STRB : valid_out=1, data_out_*=0, COMPUTE_BEATS consecutive cycles; on last beat
//          frame_sent=1, full[rd_bank]<=0, rd_bank toggles; -> GAP (GAP_CYCLES>0) else IDLE.
//   GAP  : valid_out=0 for GAP_CYCLES cycles -> IDLE.
//  Latency: last input beat accepted on edge T -> full set at T; first valid_out high
//   in the cycle after edge T+1 (2-edge latency). Frame occupies FRAME_LEN+COMPUTE_BEATS
//   contiguous valid cycles, never broken.
//  Boundaries: both banks full -> in_ready=0, input beats ignored. A bank is set only by
//   the write side and cleared only by the TX side; a write completing bank A in the
//   same cycle TX releases bank B is legal and both updates take effect. Back-to-back
//   frames with GAP_CYCLES=0: IDLE lasts exactly one cycle between frames.
//  Widths: data passes bit-exact, no sign change, rounding or saturation.
//  No downstream back-pressure: FC consumes every valid beat.
// STRUCTURE
//  Shared package/header: DW, FRAME_LEN, COMPUTE_BEATS defaults shared with
//   fully_connected; TX state encodings (IDLE/FEAT/STRB/GAP).
//  One sub-module: fc_pingpong_buf (2 x FRAME_LEN x 3*DW, 1 write port, 1 sync read
//   port, full[1:0] flags); read issued one cycle ahead so data_out aligns with valid_out.
//  Counters sized with CLOG2 of max(FRAME_LEN, COMPUTE_BEATS, GAP_CYCLES+1).
// TESTING
//  1 Single frame: 16 beats d1=i, d2=100+i, d3=-i (i=0..15), no gaps -> 16 valid_out
//    beats reproducing same order/values, then 11 zero strobes, frame_sent on beat 27.
//  2 Sign/width: d1=12'h800, d2=12'h7FF, d3=12'hFFF -> identical bits on data_out_*.
//  3 Ping-pong: 3 frames pushed continuously -> in_ready drops after frame 2 fills
//    while frame 1 transmits; rises when frame 1 released; 3 frames out, no lost beats.
//  4 Bursty input: valid_in 1-of-3 cycles -> output still 27 contiguous valid cycles.
//  5 GAP_CYCLES=4, 2 frames -> exactly 4 valid_out=0 cycles between frame 1 last strobe
//    and frame 2 first feature beat.
//  6 Reset at input beat 7 and again mid-FEAT -> outputs return to reset values next
//    cycle; following full frame transmits correctly from bank 0.
//  Scoreboard: golden FC model fed by valid_out produces 10 expected scores per frame.

Source files
------------

// File: rtl/fc_input_streamer_pkg.sv
// Shared constants and TX state encoding for the FC input streamer.
// The default sizes match those used by the fully_connected block.
package fc_input_streamer_pkg;

  localparam int unsigned FcDw           = 12;
  localparam int unsigned FcFrameLen     = 16;
  localparam int unsigned FcComputeBeats = 11;
  localparam int unsigned FcGapCycles    = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFeat = 2'd1,
    StStrb = 2'd2,
    StGap  = 2'd3
  } tx_state_e;

  // Width of a counter that must reach max(a, b, c) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fc_pingpong_buf.sv
// Two-bank frame buffer: one write port, one registered read port, per-bank full flags.
// The read register clears to zero whenever no read is issued.
module fc_pingpong_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             set_full,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [ADDRW-1:0] rd_addr,
  input  logic             rel,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       full
);

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [1:0]       full_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_bank][rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

  // Set and release always target different banks, so both may land in one cycle.
  always_comb begin
    full_d = full;
    if (rel) full_d[rd_bank] = 1'b0;
    if (set_full) full_d[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= full_d;
    end
  end

endmodule

// File: rtl/fc_input_streamer.sv
// Collects 3-channel feature frames into a ping-pong buffer and replays each one to the
// FC layer as FRAME_LEN feature beats followed by COMPUTE_BEATS zero strobes.
module fc_input_streamer
  import fc_input_streamer_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = FcFrameLen,
  parameter int unsigned COMPUTE_BEATS = FcComputeBeats,
  parameter int unsigned GAP_CYCLES    = FcGapCycles,
  parameter int unsigned DW            = FcDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in_1,
  input  logic [DW-1:0] data_in_2,
  input  logic [DW-1:0] data_in_3,
  output logic          in_ready,
  output logic          valid_out,
  output logic [DW-1:0] data_out_1,
  output logic [DW-1:0] data_out_2,
  output logic [DW-1:0] data_out_3,
  output logic          busy,
  output logic          frame_sent
);

  localparam int unsigned CntW  = cnt_width(FRAME_LEN, COMPUTE_BEATS, GAP_CYCLES + 1);
  localparam int unsigned AddrW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CntW-1:0]  FeatLast = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0]  StrbLast = CntW'(COMPUTE_BEATS - 1);
  localparam logic [CntW-1:0]  StrbPen  = CntW'(COMPUTE_BEATS - 2);
  localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYCLES - 2);
  localparam logic [AddrW-1:0] WrLast   = AddrW'(FRAME_LEN - 1);

  logic [1:0]       full;
  logic [3*DW-1:0]  rd_data;

  // Write side
  logic [AddrW-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             accept, set_full;

  assign in_ready = ~full[wr_bank_q];
  assign accept   = valid_in & in_ready;
  assign set_full = accept & (wr_cnt_q == WrLast);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (set_full) begin
      wr_cnt_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (accept) begin
      wr_cnt_d = wr_cnt_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // TX side
  tx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             valid_q, valid_d;
  logic             sent_q, sent_d;
  logic             rd_en, rel;
  logic [AddrW-1:0] rd_addr;

  // The read for the next output beat is issued in the current cycle, so the registered
  // read data lines up with the registered valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    valid_d   = 1'b0;
    sent_d    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    rel       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full[rd_bank_q]) begin
          state_d = StFeat;
          cnt_d   = '0;
          valid_d = 1'b1;
          rd_en   = 1'b1;
        end
      end
      StFeat: begin
        valid_d = 1'b1;
        if (cnt_q == FeatLast) begin
          state_d = StStrb;
          cnt_d   = '0;
          sent_d  = (COMPUTE_BEATS == 1);
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          rd_en   = 1'b1;
          rd_addr = AddrW'(cnt_q + CntW'(1));
        end
      end
      StStrb: begin
        if (cnt_q == StrbLast) begin
          rel       = 1'b1;
          rd_bank_d = ~rd_bank_q;
          cnt_d     = '0;
          // IDLE always costs one idle cycle, so GAP covers the remaining GAP_CYCLES-1.
          state_d   = (GAP_CYCLES > 1) ? StGap : StIdle;
        end else begin
          valid_d = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
          sent_d  = (cnt_q == StrbPen);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      sent_q    <= sent_d;
    end
  end

  fc_pingpong_buf #(
    .DEPTH(FRAME_LEN),
    .WIDTH(3 * DW),
    .ADDRW(AddrW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_cnt_q),
    .wr_data ({data_in_1, data_in_2, data_in_3}),
    .set_full(set_full),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rel     (rel),
    .rd_data (rd_data),
    .full    (full)
  );

  assign valid_out  = valid_q;
  assign frame_sent = sent_q;
  assign busy       = (state_q != StIdle);
  assign data_out_1 = rd_data[3*DW-1:2*DW];
  assign data_out_2 = rd_data[2*DW-1:DW];
  assign data_out_3 = rd_data[DW-1:0];

endmodule

// File: tb/tb_fc_input_streamer.sv
// Bench for fc_input_streamer: two instances (no gap, 4-cycle gap) share one input stream
// and are checked every cycle against a frame-queue model, plus directed sequences.
module tb_fc_input_streamer;

  localparam int FL   = 16;
  localparam int CB   = 11;
  localparam int FLEN = FL + CB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] d1 = '0, d2 = '0, d3 = '0;

  logic        rdy_a, vo_a, busy_a, fs_a;
  logic [11:0] o1_a, o2_a, o3_a;
  logic        rdy_b, vo_b, busy_b, fs_b;
  logic [11:0] o1_b, o2_b, o3_b;

  always #5 clk = ~clk;

  fc_input_streamer #(.GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
    .in_ready(rdy_a), .valid_out(vo_a),
    .data_out_1(o1_a), .data_out_2(o2_a), .data_out_3(o3_a),
    .busy(busy_a), .frame_sent(fs_a)
  );

  fc_input_streamer #(.GAP_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
    .in_ready(rdy_b), .valid_out(vo_b),
    .data_out_1(o1_b), .data_out_2(o2_b), .data_out_3(o3_b),
    .busy(busy_b), .frame_sent(fs_b)
  );

  // Model: complete frames waiting/being sent, the partial frame, and the TX position
  // within the 27-beat frame timeline (-1 when not transmitting).
  logic [35:0] fq_a[$], fq_b[$];
  logic [35:0] part [2][FL];
  int part_n[2], held[2], pos[2], wait_n[2];
  int gap_cfg[2] = '{0, 4};

  int n_tests = 0, n_fail = 0;
  int fs_cnt, run_a, max_run_a;
  bit saw_low;

  typedef struct {
    logic [11:0] d1, d2, d3;
    logic [11:0] e1, e2, e3;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [35:0] fq_get(input int k, input int i);
    return (k == 0) ? fq_a[i] : fq_b[i];
  endfunction

  task automatic model_reset();
    fq_a.delete();
    fq_b.delete();
    for (int k = 0; k < 2; k++) begin
      part_n[k] = 0; held[k] = 0; pos[k] = -1; wait_n[k] = 0;
    end
  endtask

  task automatic model_step();
    bit acc, rel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      acc = valid_in && (held[k] < 2);
      rel = 1'b0;
      if (pos[k] == FLEN - 1) begin
        rel = 1'b1;
        pos[k] = -1;
        wait_n[k] = (gap_cfg[k] > 1) ? gap_cfg[k] - 1 : 0;
      end else if (pos[k] >= 0) begin
        pos[k]++;
      end else if (wait_n[k] > 0) begin
        wait_n[k]--;
      end else if (held[k] > 0) begin
        pos[k] = 0;
      end
      if (rel) begin
        for (int i = 0; i < FL; i++) begin
          if (k == 0) void'(fq_a.pop_front()); else void'(fq_b.pop_front());
        end
        held[k]--;
      end
      if (acc) begin
        part[k][part_n[k]] = {d1, d2, d3};
        part_n[k]++;
        if (part_n[k] == FL) begin
          for (int i = 0; i < FL; i++) begin
            if (k == 0) fq_a.push_back(part[k][i]); else fq_b.push_back(part[k][i]);
          end
          held[k]++;
          part_n[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_dut(input string n, input int k, input logic rdy, input logic vo,
                         input logic bz, input logic fs, input logic [11:0] x1,
                         input logic [11:0] x2, input logic [11:0] x3);
    logic [35:0] e;
    e = (pos[k] >= 0 && pos[k] < FL) ? fq_get(k, pos[k]) : 36'h0;
    cmp({n, ".in_ready"}, rdy, held[k] < 2);
    cmp({n, ".valid_out"}, vo, pos[k] >= 0);
    cmp({n, ".busy"}, bz, (pos[k] >= 0) || (wait_n[k] > 0));
    cmp({n, ".frame_sent"}, fs, pos[k] == FLEN - 1);
    cmp({n, ".data_out_1"}, x1, e[35:24]);
    cmp({n, ".data_out_2"}, x2, e[23:12]);
    cmp({n, ".data_out_3"}, x3, e[11:0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_dut("a", 0, rdy_a, vo_a, busy_a, fs_a, o1_a, o2_a, o3_a);
    chk_dut("b", 1, rdy_b, vo_b, busy_b, fs_b, o1_b, o2_b, o3_b);
    if (!rdy_a) saw_low = 1'b1;
    if (fs_a) fs_cnt++;
    if (vo_a) begin
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
  endtask

  // Offer one beat once both instances can take it, so their input streams stay equal.
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    int guard = 0;
    while (!(rdy_a && rdy_b) && guard < 200) begin
      valid_in = 1'b0;
      step();
      guard++;
    end
    cmp("send_wait_ready", rdy_a && rdy_b, 1);
    valid_in = 1'b1;
    d1 = a; d2 = b; d3 = c;
    step();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string n);
    int g = 0;
    while (!vo_a && g < 20) begin
      step();
      g++;
    end
    cmp(n, vo_a, 1);
  endtask

  task automatic do_reset(input string n);
    valid_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp({n, ".valid_out"}, vo_a, 0);
    cmp({n, ".data_out_1"}, o1_a, 0);
    cmp({n, ".in_ready"}, rdy_a, 1);
    cmp({n, ".busy"}, busy_a, 0);
    cmp({n, ".b_valid_out"}, vo_b, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int nb, gap_a, gap_b, cnt_a, cnt_b, st_a, st_b;
    logic [11:0] first;

    model_reset();
    step();
    cmp("reset.in_ready", rdy_a, 1);
    cmp("reset.valid_out", vo_a, 0);
    cmp("reset.busy", busy_a, 0);
    cmp("reset.frame_sent", fs_a, 0);
    cmp("reset.data_out_3", o3_a, 0);
    rst_n = 1'b1;
    idle(2);

    // Single frame: order, values, latency, contiguity, frame_sent position.
    for (int i = 0; i < FL; i++) send(12'(i), 12'(100 + i), 12'(0 - i));
    valid_in = 1'b0;
    cmp("t1.latency_edge1", vo_a, 0);
    step();
    cmp("t1.latency_edge2", vo_a, 1);
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (vo_a) begin
        cmp("t1.d1", o1_a, (nb < FL) ? 12'(nb) : 12'h0);
        cmp("t1.d2", o2_a, (nb < FL) ? 12'(100 + nb) : 12'h0);
        cmp("t1.d3", o3_a, (nb < FL) ? 12'(0 - nb) : 12'h0);
        cmp("t1.frame_sent", fs_a, nb == FLEN - 1);
        nb++;
      end else if (nb > 0) begin
        break;
      end
      step();
    end
    cmp("t1.beats", nb, FLEN);
    idle(80);

    // Sign/width table.
    tbl[0] = '{12'h800, 12'h7FF, 12'hFFF, 12'h800, 12'h7FF, 12'hFFF};
    tbl[1] = '{12'h000, 12'h001, 12'hFFE, 12'h000, 12'h001, 12'hFFE};
    tbl[2] = '{12'hFFF, 12'h800, 12'h7FF, 12'hFFF, 12'h800, 12'h7FF};
    tbl[3] = '{12'hAAA, 12'h555, 12'h801, 12'hAAA, 12'h555, 12'h801};
    for (int i = 4; i < 16; i++) begin
      tbl[i].d1 = 12'(i * 273);
      tbl[i].d2 = 12'(4095 - i * 97);
      tbl[i].d3 = 12'(i << 7);
      tbl[i].e1 = tbl[i].d1;
      tbl[i].e2 = tbl[i].d2;
      tbl[i].e3 = tbl[i].d3;
    end
    for (int i = 0; i < 16; i++) send(tbl[i].d1, tbl[i].d2, tbl[i].d3);
    valid_in = 1'b0;
    wait_valid("t2.start");
    for (int i = 0; i < 16; i++) begin
      cmp("t2.data_out_1", o1_a, tbl[i].e1);
      cmp("t2.data_out_2", o2_a, tbl[i].e2);
      cmp("t2.data_out_3", o3_a, tbl[i].e3);
      step();
    end
    idle(80);

    // Ping-pong: three frames pushed back to back.
    saw_low = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 3 * FL; i++) send(12'($urandom), 12'($urandom), 12'($urandom));
    idle(120);
    cmp("t3.in_ready_dropped", saw_low, 1);
    cmp("t3.frames_sent", fs_cnt, 3);
    cmp("t3.in_ready_back", rdy_a, 1);

    // Bursty input: one beat every third cycle, output must stay contiguous.
    run_a = 0;
    max_run_a = 0;
    for (int i = 0; i < FL; i++) begin
      send(12'($urandom), 12'($urandom), 12'($urandom));
      idle(2);
    end
    idle(60);
    cmp("t4.contiguous_run", max_run_a, FLEN);

    // Gap between two back-to-back frames: 1 cycle with no gap, 4 with GAP_CYCLES=4.
    for (int i = 0; i < 2 * FL; i++) send(12'($urandom), 12'($urandom), 12'($urandom));
    valid_in = 1'b0;
    gap_a = -1; gap_b = -1; cnt_a = 0; cnt_b = 0; st_a = 0; st_b = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (st_a == 1) begin
        if (vo_a) begin gap_a = cnt_a; st_a = 2; end else cnt_a++;
      end
      if (st_b == 1) begin
        if (vo_b) begin gap_b = cnt_b; st_b = 2; end else cnt_b++;
      end
      if (fs_a && st_a == 0) st_a = 1;
      if (fs_b && st_b == 0) st_b = 1;
    end
    cmp("t5.gap_no_gap_cfg", gap_a, 1);
    cmp("t5.gap_gap4_cfg", gap_b, 4);
    idle(20);

    // Reset during input and during FEAT, then a clean frame.
    for (int i = 0; i < 7; i++) send(12'(i + 1), 12'(i + 2), 12'(i + 3));
    do_reset("t6.rst_in");
    for (int i = 0; i < FL; i++) send(12'($urandom), 12'($urandom), 12'($urandom));
    valid_in = 1'b0;
    wait_valid("t6.feat_start");
    idle(3);
    do_reset("t6.rst_feat");
    for (int i = 0; i < FL; i++) send(12'(3 * i + 5), 12'(7 * i), 12'(0 - 2 * i));
    valid_in = 1'b0;
    wait_valid("t6.after_reset_start");
    first = 12'd5;
    cmp("t6.first_beat", o1_a, first);
    idle(80);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) != 0 && rdy_a && rdy_b) begin
        valid_in = 1'b1;
        d1 = 12'($urandom); d2 = 12'($urandom); d3 = 12'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      step();
    end
    idle(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
